// File: rtl/uart_rx_byte_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud divisor helper.
// Also used by the matching uart_tx.
package uart_rx_byte_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } uart_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_byte_sync.sv
// uart_rx_sync: two-flop synchroniser for the raw serial line.
// Both flops reset to 1 so a held reset looks like an idle line.
module uart_rx_sync
   import uart_rx_byte_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver delivering bytes on a valid/ready interface.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx_byte
   import uart_rx_byte_pkg::*;
#(
   parameter int CLK_FREQ = 12000000,
   parameter int BAUD     = 115200
`ifdef UART_RX_PARITY_EN
   ,parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int BCW          = $clog2(CLKS_PER_BIT);
   localparam int BITW         = $clog2(DATA_BITS);
   localparam logic [BCW-1:0]  BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
   localparam logic [BCW-1:0]  HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BITW-1:0] BIT_LAST  = BITW'(DATA_BITS - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_rate
         $error("uart_rx_byte: CLKS_PER_BIT must be at least 4");
      end
   endgenerate

   logic w_rxs;

   uart_rx_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (rx),
      .o_sync  (w_rxs)
   );

   uart_state_t          r_state;
   logic [BCW-1:0]       r_baud_cnt;
   logic [BITW-1:0]      r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic                 r_parity_err;
   logic                 r_busy;
   logic                 w_tick;

   assign w_tick = (r_baud_cnt == BAUD_LAST);

`ifdef UART_RX_PARITY_EN
   logic r_par_bit;
   logic w_par_bad;
   assign w_par_bad = (((^r_shift) ^ r_par_bit) != PARITY_ODD);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_baud_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_parity_err <= 1'b0;
         r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
`endif
      end else begin
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_parity_err <= 1'b0;
         // A delivery later in this block overrides this consume.
         if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (!w_rxs) begin
                  r_state    <= ST_START;
                  r_busy     <= 1'b1;
                  r_baud_cnt <= '0;
               end
            end

            ST_START: begin
               if (r_baud_cnt == HALF_LAST) begin
                  r_baud_cnt <= '0;
                  if (w_rxs) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= '0;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               r_baud_cnt <= w_tick ? '0 : r_baud_cnt + 1'b1;
               if (w_tick) begin
                  r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               r_baud_cnt <= w_tick ? '0 : r_baud_cnt + 1'b1;
               if (w_tick) begin
                  r_par_bit <= w_rxs;
                  r_state   <= ST_STOP;
               end
            end
`endif

            ST_STOP: begin
               r_baud_cnt <= w_tick ? '0 : r_baud_cnt + 1'b1;
               if (w_tick) begin
`ifdef UART_RX_PARITY_EN
                  r_parity_err <= w_par_bad;
`endif
                  if (w_rxs) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     if (!r_valid || rx_ready) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_WAIT_IDLE;
                  end
               end
            end

            // Hold here through a break so a long low line cannot restart a frame.
            ST_WAIT_IDLE: begin
               if (w_rxs) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data    = r_data;
   assign rx_valid   = r_valid;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;
   assign parity_err = r_parity_err;
   assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 12 clocks per bit: table of frames plus
// hand-written sequences for overrun, break, glitch, reset and parity cases.
module tb_uart_rx_byte;

   localparam int CLK_FREQ = 12000000;
   localparam int BAUD     = 1000000;
   localparam int C        = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   // Falling start edge to rx_valid rising: sync + half bit + rest of frame + 1.
   localparam int LAT = 2 + C/2 + (FRAME_BITS - 1) * C + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;
   logic       busy;

   uart_rx_byte #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor, sampled on the falling edge.
   int         n_rise = 0, n_vcyc = 0, n_fe = 0, n_ov = 0, n_pe = 0, n_busy = 0, n_unstable = 0;
   int         rise_cyc = 0, ov_cyc = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      if (rx_valid && !prev_valid) begin
         n_rise   = n_rise + 1;
         rise_cyc = cyc;
      end
      if (rx_valid && prev_valid && rx_data != prev_data) n_unstable = n_unstable + 1;
      if (rx_valid)   n_vcyc = n_vcyc + 1;
      if (frame_err)  n_fe = n_fe + 1;
      if (overrun) begin
         n_ov   = n_ov + 1;
         ov_cyc = cyc;
      end
      if (parity_err) n_pe = n_pe + 1;
      if (busy)       n_busy = n_busy + 1;
      prev_valid = rx_valid;
      prev_data  = rx_data;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      else
         n_pass++;
   endtask

`ifdef UART_RX_PARITY_EN
   logic par_flip = 1'b0;
`endif

   // All drivers start and end 1 ns after a rising edge.
   task automatic drive_bit(input logic v);
      rx = v;
      repeat (C) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, output int start);
      start = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ par_flip);
`endif
      drive_bit(stop);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_data;
      int         exp_rise;
      int         exp_fe;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int st, st2, b_rise, b_vcyc, b_fe, b_ov, b_pe, b_busy;

      vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
      vecs[3] = '{8'h55, 1'b0, 8'hFF, 0, 1};
      vecs[4] = '{8'h3C, 1'b1, 8'h3C, 1, 0};
      vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0};

      #3 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset rx_data", rx_data, 8'h00);
      check("reset rx_valid", rx_valid, 1'b0);
      check("reset frame_err", frame_err, 1'b0);
      check("reset overrun", overrun, 1'b0);
      check("reset parity_err", parity_err, 1'b0);
      check("reset busy", busy, 1'b0);
      rst = 1'b0;
      idle(2 * C);

      // Table: frames with rx_ready held high.
      rx_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         b_rise = n_rise; b_vcyc = n_vcyc; b_fe = n_fe; b_ov = n_ov; b_pe = n_pe;
         send_frame(vecs[i].data, vecs[i].stop, st);
         idle(2 * C);
         $display("vec %0d byte=0x%0h stop=%0b rx_data=0x%0h rises=%0d fe=%0d",
                  i, vecs[i].data, vecs[i].stop, rx_data, n_rise - b_rise, n_fe - b_fe);
         check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
         check($sformatf("vec%0d valid rises", i), n_rise - b_rise, vecs[i].exp_rise);
         check($sformatf("vec%0d valid cycles", i), n_vcyc - b_vcyc, vecs[i].exp_rise);
         check($sformatf("vec%0d frame_err", i), n_fe - b_fe, vecs[i].exp_fe);
         check($sformatf("vec%0d overrun", i), n_ov - b_ov, 0);
         check($sformatf("vec%0d parity_err", i), n_pe - b_pe, 0);
         if (vecs[i].exp_rise == 1)
            check($sformatf("vec%0d latency", i), rise_cyc - st, LAT);
      end

      // Overrun: two frames back-to-back with rx_ready low.
      rx_ready = 1'b0;
      b_rise = n_rise; b_ov = n_ov;
      send_frame(8'h3C, 1'b1, st);
      send_frame(8'h81, 1'b1, st2);
      idle(C);
      $display("overrun seq rx_data=0x%0h rx_valid=%0b overruns=%0d", rx_data, rx_valid, n_ov - b_ov);
      check("ovr rx_data", rx_data, 8'h3C);
      check("ovr rx_valid", rx_valid, 1'b1);
      check("ovr pulses", n_ov - b_ov, 1);
      check("ovr pulse cycle", ov_cyc - st2, LAT);
      check("ovr rises", n_rise - b_rise, 1);
      rx_ready = 1'b1;
      @(negedge clk);
      check("ovr valid before edge", rx_valid, 1'b1);
      @(negedge clk);
      check("ovr valid after accept", rx_valid, 1'b0);
      @(posedge clk);
      #1;

      // Bad stop bit followed by a long break.
      b_rise = n_rise; b_fe = n_fe;
      send_frame(8'h55, 1'b0, st);
      b_busy = n_busy;
      rx = 1'b0;
      repeat (30 * C) @(posedge clk);
      #1;
      check("break busy held", n_busy - b_busy, 30 * C);
      rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      $display("break seq frame_errs=%0d busy=%0b", n_fe - b_fe, busy);
      check("break busy released", busy, 1'b0);
      check("break frame_err", n_fe - b_fe, 1);
      check("break no valid", n_rise - b_rise, 0);
      idle(C);
      b_rise = n_rise;
      send_frame(8'h12, 1'b1, st);
      idle(2 * C);
      $display("post-break byte rx_data=0x%0h", rx_data);
      check("post-break rx_data", rx_data, 8'h12);
      check("post-break latency", rise_cyc - st, LAT);
      check("post-break rises", n_rise - b_rise, 1);

      // Three-clock low glitch on an idle line.
      b_rise = n_rise; b_fe = n_fe; b_ov = n_ov; b_busy = n_busy;
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idle(2 * C);
      $display("glitch busy cycles=%0d", n_busy - b_busy);
      check("glitch busy cycles", n_busy - b_busy, C/2);
      check("glitch no valid", n_rise - b_rise, 0);
      check("glitch no flags", (n_fe - b_fe) + (n_ov - b_ov), 0);

      // Reset mid-frame with a byte pending.
      rx_ready = 1'b0;
      send_frame(8'h5A, 1'b1, st);
      idle(4);
      check("pend rx_valid", rx_valid, 1'b1);
      for (int i = 0; i < 5; i++) drive_bit(1'b0);
      rx = 1'b1;
      repeat (C/2) @(posedge clk);
      #1;
      check("pre-rst busy", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      $display("mid-frame reset rx_data=0x%0h rx_valid=%0b busy=%0b", rx_data, rx_valid, busy);
      check("rst rx_data", rx_data, 8'h00);
      check("rst rx_valid", rx_valid, 1'b0);
      check("rst busy", busy, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      rx_ready = 1'b1;
      idle(2 * C);
      send_frame(8'h0F, 1'b1, st);
      idle(2 * C);
      $display("post-reset byte rx_data=0x%0h", rx_data);
      check("post-rst rx_data", rx_data, 8'h0F);
      check("post-rst latency", rise_cyc - st, LAT);

`ifdef UART_RX_PARITY_EN
      b_pe = n_pe;
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1, st);
      idle(2 * C);
      $display("parity bad rx_data=0x%0h parity_errs=%0d", rx_data, n_pe - b_pe);
      check("par bad pulse", n_pe - b_pe, 1);
      check("par bad rx_data", rx_data, 8'h07);
      b_pe = n_pe;
      par_flip = 1'b0;
      send_frame(8'h07, 1'b1, st);
      idle(2 * C);
      $display("parity good rx_data=0x%0h parity_errs=%0d", rx_data, n_pe - b_pe);
      check("par good pulse", n_pe - b_pe, 0);
      check("par good latency", rise_cyc - st, LAT);
`endif

      check("data stable while valid", n_unstable, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
